// File: rtl/root_hub_router.sv
// Root-FPGA hub switch: decodes the destination FPGA ID of each word from the leaves or the root controller
// and forwards it through per-source input buffers and per-destination round-robin output registers.
module root_hub_router #(
   parameter int unsigned LEAF_COUNT              = 2,
   parameter int unsigned FPGAID_WIDTH            = 2,
   parameter int unsigned HUB_FIFO_PHYSICAL_WIDTH = 64
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic [HUB_FIFO_PHYSICAL_WIDTH*LEAF_COUNT-1:0] leaf_in_data,
   input  logic [LEAF_COUNT-1:0]                         leaf_in_valid,
   output logic [LEAF_COUNT-1:0]                         leaf_in_ready,
   output logic [HUB_FIFO_PHYSICAL_WIDTH*LEAF_COUNT-1:0] leaf_out_data,
   output logic [LEAF_COUNT-1:0]                         leaf_out_valid,
   input  logic [LEAF_COUNT-1:0]                         leaf_out_ready,
   input  logic [HUB_FIFO_PHYSICAL_WIDTH-1:0]            root_in_data,
   input  logic                                          root_in_valid,
   output logic                                          root_in_ready,
   output logic [HUB_FIFO_PHYSICAL_WIDTH-1:0]            root_out_data,
   output logic                                          root_out_valid,
   input  logic                                          root_out_ready,
   output logic                                          has_flying_messages
);

   localparam int unsigned W  = HUB_FIFO_PHYSICAL_WIDTH;
   localparam int unsigned NS = LEAF_COUNT + 1;
   localparam int unsigned DW = (NS > 1) ? $clog2(NS) : 1;

   logic [NS-1:0] w_src_valid;
   logic [W-1:0]  w_src_data [NS];
   logic [NS-1:0] w_src_ready;
   logic [NS-1:0] w_src_granted;
   logic [NS-1:0] w_dst_ready;
   logic [NS-1:0] w_gnt_any;
   logic [DW-1:0] w_gnt_idx [NS];

   logic [NS-1:0] r_buf_valid;
   logic [W-1:0]  r_buf_data [NS];
   logic [DW-1:0] r_buf_dest [NS];
   logic [NS-1:0] r_out_valid;
   logic [W-1:0]  r_out_data [NS];
   logic [DW-1:0] r_ptr [NS];
   logic          r_flying;

   // IDs 1..LEAF_COUNT address a leaf (including loopback); everything else goes to the root
   function automatic logic [DW-1:0] f_decode(input logic [W-1:0] data);
      int unsigned id;
      id = 32'(data[W-1 -: FPGAID_WIDTH]);
      if ((id >= 32'd1) && (id <= LEAF_COUNT)) return DW'(id - 32'd1);
      return DW'(LEAF_COUNT);
   endfunction

   for (genvar i = 0; i < LEAF_COUNT; i++) begin : g_leaf
      assign w_src_data[i]               = leaf_in_data[i*W +: W];
      assign leaf_out_data[i*W +: W]     = r_out_data[i];
   end
   assign w_src_data[LEAF_COUNT] = root_in_data;

   assign w_src_valid         = {root_in_valid, leaf_in_valid};
   assign w_dst_ready         = {root_out_ready, leaf_out_ready};
   assign w_src_ready         = ~r_buf_valid | w_src_granted;
   assign leaf_in_ready       = w_src_ready[LEAF_COUNT-1:0];
   assign root_in_ready       = w_src_ready[LEAF_COUNT];
   assign leaf_out_valid      = r_out_valid[LEAF_COUNT-1:0];
   assign root_out_valid      = r_out_valid[LEAF_COUNT];
   assign root_out_data       = r_out_data[LEAF_COUNT];
   assign has_flying_messages = r_flying;

   // Per-destination round-robin: search starts one past the last granted source
   always_comb begin
      int unsigned v_idx;
      logic        v_found;
      v_idx         = 0;
      v_found       = 1'b0;
      w_gnt_any     = '0;
      w_src_granted = '0;
      for (int d = 0; d < NS; d++) begin
         w_gnt_idx[d] = r_ptr[d];
         v_found      = 1'b0;
         if (!r_out_valid[d] || w_dst_ready[d]) begin
            for (int k = 1; k <= NS; k++) begin
               v_idx = (32'(r_ptr[d]) + 32'(k)) % NS;
               if (!v_found && r_buf_valid[DW'(v_idx)] && (r_buf_dest[DW'(v_idx)] == DW'(d))) begin
                  v_found      = 1'b1;
                  w_gnt_idx[d] = DW'(v_idx);
               end
            end
         end
         w_gnt_any[d] = v_found;
         if (v_found) w_src_granted[w_gnt_idx[d]] = 1'b1;
      end
   end

   // Buffers drain and refill at the same edge; outputs consume and reload at the same edge
   always_ff @(posedge clk) begin
      if (reset) begin
         r_buf_valid <= '0;
         r_out_valid <= '0;
         r_flying    <= 1'b0;
         for (int s = 0; s < NS; s++) begin
            r_buf_data[s] <= '0;
            r_buf_dest[s] <= '0;
            r_out_data[s] <= '0;
            r_ptr[s]      <= DW'(LEAF_COUNT);
         end
      end else begin
         for (int s = 0; s < NS; s++) begin
            if (w_src_valid[s] && w_src_ready[s]) begin
               r_buf_valid[s] <= 1'b1;
               r_buf_data[s]  <= w_src_data[s];
               r_buf_dest[s]  <= f_decode(w_src_data[s]);
            end else if (w_src_granted[s]) begin
               r_buf_valid[s] <= 1'b0;
            end
         end
         for (int d = 0; d < NS; d++) begin
            if (w_gnt_any[d]) begin
               r_out_valid[d] <= 1'b1;
               r_out_data[d]  <= r_buf_data[w_gnt_idx[d]];
               r_ptr[d]       <= w_gnt_idx[d];
            end else if (w_dst_ready[d]) begin
               r_out_valid[d] <= 1'b0;
            end
         end
         r_flying <= (|r_buf_valid) | (|r_out_valid);
      end
   end

endmodule

// File: tb/tb_root_hub_router.sv
// Self-checking bench for root_hub_router: directed scenarios plus a randomized phase,
// checked by a per-source ordered scoreboard and a word-count model of has_flying_messages.
module tb_root_hub_router;

   localparam int unsigned LC = 2;
   localparam int unsigned W  = 64;
   localparam int unsigned NS = LC + 1;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [W*LC-1:0] leaf_in_data = '0;
   logic [LC-1:0]   leaf_in_valid = '0;
   logic [LC-1:0]   leaf_in_ready;
   logic [W*LC-1:0] leaf_out_data;
   logic [LC-1:0]   leaf_out_valid;
   logic [LC-1:0]   leaf_out_ready = '1;
   logic [W-1:0]    root_in_data = '0;
   logic            root_in_valid = 1'b0;
   logic            root_in_ready;
   logic [W-1:0]    root_out_data;
   logic            root_out_valid;
   logic            root_out_ready = 1'b1;
   logic            has_flying_messages;

   root_hub_router #(.LEAF_COUNT(LC), .FPGAID_WIDTH(2), .HUB_FIFO_PHYSICAL_WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .leaf_in_data(leaf_in_data), .leaf_in_valid(leaf_in_valid), .leaf_in_ready(leaf_in_ready),
      .leaf_out_data(leaf_out_data), .leaf_out_valid(leaf_out_valid), .leaf_out_ready(leaf_out_ready),
      .root_in_data(root_in_data), .root_in_valid(root_in_valid), .root_in_ready(root_in_ready),
      .root_out_data(root_out_data), .root_out_valid(root_out_valid), .root_out_ready(root_out_ready),
      .has_flying_messages(has_flying_messages)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned src;
      int unsigned dst;
      logic [63:0] data;
   } pend_t;

   pend_t       pend[$];
   int          checks = 0;
   int          errors = 0;
   logic        prev_ne = 1'b0;
   logic [2:0]  acc;
   logic [63:0] cur [NS];
   logic        cur_v [NS];
   logic [63:0] wa [8];
   logic [63:0] wb [8];
   logic [63:0] w0, w1, w2;
   int unsigned seq = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Word layout used by the bench: [63:62] dest id, [61:60] source, [59:32] sequence, [31:0] random
   function automatic logic [63:0] mk(input int unsigned id, input int unsigned src);
      seq++;
      return {2'(id), 2'(src), 28'(seq), 32'($urandom)};
   endfunction

   function automatic int unsigned exp_dst(input logic [63:0] w);
      int unsigned id = 32'(w[63:62]);
      return ((id >= 1) && (id <= LC)) ? id - 1 : LC;
   endfunction

   function automatic logic ov(input int unsigned d);
      if (d < LC) return leaf_out_valid[d];
      return root_out_valid;
   endfunction
   function automatic logic ordy(input int unsigned d);
      if (d < LC) return leaf_out_ready[d];
      return root_out_ready;
   endfunction
   function automatic logic [63:0] od(input int unsigned d);
      if (d < LC) return leaf_out_data[d*W +: W];
      return root_out_data;
   endfunction
   function automatic logic iv(input int unsigned s);
      if (s < LC) return leaf_in_valid[s];
      return root_in_valid;
   endfunction
   function automatic logic ir(input int unsigned s);
      if (s < LC) return leaf_in_ready[s];
      return root_in_ready;
   endfunction
   function automatic logic [63:0] idata(input int unsigned s);
      if (s < LC) return leaf_in_data[s*W +: W];
      return root_in_data;
   endfunction

   // Mid-cycle monitor: flying flag vs words held, deliveries vs scoreboard, then record accepts
   task automatic capture();
      logic [63:0] w;
      int unsigned src;
      logic found;
      acc = '0;
      if (reset) begin
         pend.delete();
         prev_ne = 1'b0;
         return;
      end
      chk("flying", 64'(has_flying_messages), 64'(prev_ne));
      prev_ne = (pend.size() != 0);
      for (int unsigned d = 0; d < NS; d++) begin
         if (ov(d) && ordy(d)) begin
            w = od(d);
            src = 32'(w[61:60]);
            found = 1'b0;
            for (int i = 0; i < pend.size(); i++) begin
               if (!found && (pend[i].dst == d) && (pend[i].src == src)) begin
                  chk($sformatf("deliver_d%0d", d), w, pend[i].data);
                  pend.delete(i);
                  found = 1'b1;
               end
            end
            chk($sformatf("deliver_known_d%0d", d), 64'(found), 64'd1);
         end
      end
      for (int unsigned s = 0; s < NS; s++) begin
         if (iv(s) && ir(s)) begin
            pend.push_back('{src: s, dst: exp_dst(idata(s)), data: idata(s)});
            acc[s] = 1'b1;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      capture();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int unsigned s, input logic [63:0] w, input logic v);
      if (s < LC) begin
         leaf_in_data[s*W +: W] = w;
         leaf_in_valid[s] = v;
      end else begin
         root_in_data = w;
         root_in_valid = v;
      end
   endtask

   task automatic idle_inputs();
      leaf_in_valid = '0;
      root_in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      leaf_out_ready = '1;
      root_out_ready = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Reset state
      do_reset();
      chk("rst_leaf_out_valid", 64'(leaf_out_valid), 64'd0);
      chk("rst_root_out_valid", 64'(root_out_valid), 64'd0);
      chk("rst_flying", 64'(has_flying_messages), 64'd0);
      chk("rst_leaf_in_ready", 64'(leaf_in_ready), 64'h3);
      chk("rst_root_in_ready", 64'(root_in_ready), 64'd1);
      chk("rst_leaf_out_data", 64'(leaf_out_data), 64'd0);
      chk("rst_root_out_data", root_out_data, 64'd0);

      // Single word leaf0 -> id 2: two-cycle latency, flying high for two cycles
      w0 = mk(2, 0);
      drive(0, w0, 1'b1);
      cycle();
      idle_inputs();
      chk("single_t0_valid", 64'(leaf_out_valid), 64'd0);
      cycle();
      chk("single_t1_valid", 64'(leaf_out_valid), 64'h2);
      chk("single_t1_data", leaf_out_data[W +: W], w0);
      chk("single_t1_fly", 64'(has_flying_messages), 64'd1);
      cycle();
      chk("single_t2_valid", 64'(leaf_out_valid), 64'd0);
      chk("single_t2_fly", 64'(has_flying_messages), 64'd1);
      cycle();
      chk("single_t3_fly", 64'(has_flying_messages), 64'd0);

      // Contention: three sources to id 1 are delivered in source order 0,1,2
      do_reset();
      w0 = mk(1, 0); w1 = mk(1, 1); w2 = mk(1, 2);
      drive(0, w0, 1'b1); drive(1, w1, 1'b1); drive(2, w2, 1'b1);
      cycle();
      idle_inputs();
      cycle();
      chk("cont_0_valid", 64'(leaf_out_valid[0]), 64'd1);
      chk("cont_0_data", leaf_out_data[0 +: W], w0);
      cycle();
      chk("cont_1_data", leaf_out_data[0 +: W], w1);
      cycle();
      chk("cont_2_data", leaf_out_data[0 +: W], w2);
      cycle();
      chk("cont_done_valid", 64'(leaf_out_valid), 64'd0);

      // Backpressure on leaf_out[1]
      do_reset();
      leaf_out_ready[1] = 1'b0;
      w0 = mk(2, 0); w1 = mk(2, 0);
      drive(0, w0, 1'b1);
      cycle();
      drive(0, w1, 1'b1);
      #1;
      chk("bp_ready_on_grant", 64'(leaf_in_ready[0]), 64'd1);
      cycle();
      idle_inputs();
      chk("bp_hold_valid", 64'(leaf_out_valid[1]), 64'd1);
      chk("bp_hold_data", leaf_out_data[W +: W], w0);
      chk("bp_full_ready", 64'(leaf_in_ready[0]), 64'd0);
      cycle();
      chk("bp_hold2_valid", 64'(leaf_out_valid[1]), 64'd1);
      chk("bp_hold2_data", leaf_out_data[W +: W], w0);
      chk("bp_full2_ready", 64'(leaf_in_ready[0]), 64'd0);
      leaf_out_ready[1] = 1'b1;
      #1;
      chk("bp_release_ready", 64'(leaf_in_ready[0]), 64'd1);
      cycle();
      chk("bp_second_data", leaf_out_data[W +: W], w1);
      cycle();
      chk("bp_drained_valid", 64'(leaf_out_valid), 64'd0);
      chk("bp_pending", 64'(pend.size()), 64'd0);

      // Decode edges: id 0 and id 3 go to root, leaf1 -> id 2 loops back
      do_reset();
      w0 = mk(0, 0); w1 = mk(3, 1);
      drive(0, w0, 1'b1); drive(1, w1, 1'b1);
      cycle();
      idle_inputs();
      cycle();
      chk("dec_id0_valid", 64'(root_out_valid), 64'd1);
      chk("dec_id0_data", root_out_data, w0);
      chk("dec_leaf_idle", 64'(leaf_out_valid), 64'd0);
      cycle();
      chk("dec_id3_data", root_out_data, w1);
      w2 = mk(2, 1);
      drive(1, w2, 1'b1);
      cycle();
      idle_inputs();
      cycle();
      chk("dec_loop_valid", 64'(leaf_out_valid), 64'h2);
      chk("dec_loop_data", leaf_out_data[W +: W], w2);

      // Throughput: two concurrent 8-word streams at one word per cycle
      do_reset();
      for (int k = 0; k < 8; k++) begin
         wa[k] = mk(2, 0);
         wb[k] = mk(1, 1);
      end
      for (int k = 0; k < 8; k++) begin
         drive(0, wa[k], 1'b1);
         drive(1, wb[k], 1'b1);
         #1;
         chk("tput_in_ready", 64'(leaf_in_ready), 64'h3);
         cycle();
         if (k > 0) begin
            chk("tput_valid", 64'(leaf_out_valid), 64'h3);
            chk("tput_l0_data", leaf_out_data[0 +: W], wb[k-1]);
            chk("tput_l1_data", leaf_out_data[W +: W], wa[k-1]);
         end
      end
      idle_inputs();
      cycle();
      chk("tput_last_l0", leaf_out_data[0 +: W], wb[7]);
      chk("tput_last_l1", leaf_out_data[W +: W], wa[7]);
      cycle();
      chk("tput_done_valid", 64'(leaf_out_valid), 64'd0);

      // Reset with three words held in stalled outputs
      do_reset();
      drive(0, mk(2, 0), 1'b1); drive(1, mk(1, 1), 1'b1); drive(2, mk(0, 2), 1'b1);
      cycle();
      idle_inputs();
      leaf_out_ready = '0;
      root_out_ready = 1'b0;
      cycle();
      chk("rmid_held_leaf", 64'(leaf_out_valid), 64'h3);
      chk("rmid_held_root", 64'(root_out_valid), 64'd1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("rmid_leaf_valid", 64'(leaf_out_valid), 64'd0);
      chk("rmid_root_valid", 64'(root_out_valid), 64'd0);
      leaf_out_ready = '1;
      root_out_ready = 1'b1;
      cycle();
      chk("rmid_fly", 64'(has_flying_messages), 64'd0);
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("rmid_no_stale", 64'({root_out_valid, leaf_out_valid}), 64'd0);
      end

      // Randomized traffic against the scoreboard
      for (int s = 0; s < NS; s++) cur_v[s] = 1'b0;
      for (int c = 0; c < 400; c++) begin
         for (int unsigned s = 0; s < NS; s++) begin
            if (!cur_v[s] && ($urandom_range(0, 9) < 6)) begin
               cur[s] = mk($urandom_range(0, 3), s);
               cur_v[s] = 1'b1;
            end
            drive(s, cur[s], cur_v[s]);
         end
         leaf_out_ready[0] = ($urandom_range(0, 3) != 0);
         leaf_out_ready[1] = ($urandom_range(0, 3) != 0);
         root_out_ready    = ($urandom_range(0, 3) != 0);
         cycle();
         for (int s = 0; s < NS; s++) if (acc[s]) cur_v[s] = 1'b0;
      end
      idle_inputs();
      leaf_out_ready = '1;
      root_out_ready = 1'b1;
      for (int c = 0; c < 30; c++) cycle();
      chk("rand_drained", 64'(pend.size()), 64'd0);
      chk("rand_fly_idle", 64'(has_flying_messages), 64'd0);
      chk("rand_out_idle", 64'({root_out_valid, leaf_out_valid}), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
